// File: rtl/peripheral_pkg.sv
// rtl/peripheral_pkg.sv - shared state encoding and seven-segment table
package peripheral_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        READY = 1'b1
    } state_t;

    // Active-low segment codes, bit0 = a ... bit6 = g, indexed by hex digit.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex7seg_decoder.sv
// rtl/hex7seg_decoder.sv - hex nibble to active-low seven-segment code
module hex7seg_decoder
    import peripheral_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/peripheral_operand_collector.sv
// rtl/peripheral_operand_collector.sv - byte-wise operand loader with hex display
module peripheral_operand_collector
    import peripheral_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_OPERANDS = 2,
    parameter bit MSB_FIRST    = 1'b0,
    localparam int BYTES = DATA_WIDTH / 8,
    localparam int OP_W  = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1,
    localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enter,
    input  logic [7:0]                         inputdata,
    input  logic                               loaddata,
    input  logic                               clear,
    input  logic [DATA_WIDTH-1:0]              dataR,
    output logic [NUM_OPERANDS*DATA_WIDTH-1:0] operands,
    output logic [OP_W-1:0]                    op_index,
    output logic [BI_W-1:0]                    byte_index,
    output logic                               inputdata_ready,
    output logic [6:0]                         disp3,
    output logic [6:0]                         disp2,
    output logic [6:0]                         disp1,
    output logic [6:0]                         disp0
);

    localparam logic [OP_W-1:0] LAST_OP   = OP_W'(NUM_OPERANDS - 1);
    localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BYTES - 1);

    state_t                  state_q, state_d;
    logic                    enter_q;
    logic [OP_W-1:0]         op_index_q, op_index_d;
    logic [BI_W-1:0]         byte_index_q, byte_index_d;
    logic [DATA_WIDTH-1:0]   op_q [NUM_OPERANDS];
    logic                    enter_edge;
    logic                    accept;
    logic [BI_W-1:0]         wr_pos;

    assign enter_edge = enter & ~enter_q;
    assign accept     = (state_q == LOAD) && enter_edge && loaddata;
    assign wr_pos     = MSB_FIRST ? (LAST_BYTE - byte_index_q) : byte_index_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LOAD;
            enter_q      <= 1'b0;
            op_index_q   <= '0;
            byte_index_q <= '0;
        end else begin
            state_q      <= state_d;
            enter_q      <= enter;
            op_index_q   <= op_index_d;
            byte_index_q <= byte_index_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_index_d   = op_index_q;
        byte_index_d = byte_index_q;
        // clear outranks a byte arriving in the same cycle
        if (clear) begin
            state_d      = LOAD;
            op_index_d   = '0;
            byte_index_d = '0;
        end else if (accept) begin
            if (byte_index_q == LAST_BYTE) begin
                byte_index_d = '0;
                if (op_index_q == LAST_OP) begin
                    op_index_d = '0;
                    state_d    = READY;
                end else begin
                    op_index_d = op_index_q + OP_W'(1);
                end
            end else begin
                byte_index_d = byte_index_q + BI_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_OPERANDS; k++) op_q[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < NUM_OPERANDS; k++) op_q[k] <= '0;
        end else if (accept) begin
            op_q[op_index_q][{wr_pos, 3'b000} +: 8] <= inputdata;
        end
    end

    for (genvar g = 0; g < NUM_OPERANDS; g++) begin : g_flat
        assign operands[g*DATA_WIDTH +: DATA_WIDTH] = op_q[g];
    end

    assign op_index        = op_index_q;
    assign byte_index      = byte_index_q;
    assign inputdata_ready = (state_q == READY);

    logic [15:0] result_hex;
    if (DATA_WIDTH >= 16) begin : g_wide
        assign result_hex = dataR[15:0];
        if (DATA_WIDTH > 16) begin : g_hi
            logic unused_dataR_hi;
            assign unused_dataR_hi = ^dataR[DATA_WIDTH-1:16];
        end
    end else begin : g_narrow
        assign result_hex = 16'(dataR);
    end

    logic [3:0] nib3, nib2, nib1, nib0;

    always_comb begin
        nib3 = result_hex[15:12];
        nib2 = result_hex[11:8];
        nib1 = result_hex[7:4];
        nib0 = result_hex[3:0];
        if (state_q == LOAD) begin
            nib3 = 4'(op_index_q);
            nib2 = 4'(byte_index_q);
            nib1 = inputdata[7:4];
            nib0 = inputdata[3:0];
        end
    end

    hex7seg_decoder u_dec3 (.nibble(nib3), .seg(disp3));
    hex7seg_decoder u_dec2 (.nibble(nib2), .seg(disp2));
    hex7seg_decoder u_dec1 (.nibble(nib1), .seg(disp1));
    hex7seg_decoder u_dec0 (.nibble(nib0), .seg(disp0));

endmodule
